// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: owns the fetch PC, issues sequential word fetches to a
// 1-cycle synchronous instruction memory, buffers returned words with their
// PCs in a DEPTH-entry FIFO and hands them to the core over valid/ready.
// A redirect flushes the queue, kills the in-flight fetch and restarts at
// the new PC after a one-cycle FLUSH bubble.
module instr_fetch_queue #(
  parameter int             DEPTH    = 4,
  parameter int             N        = 32,
  parameter logic [N-1:0]   RESET_PC = '0
) (
  input  logic         clk,
  input  logic         reset,
  output logic         imem_req,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_rdata,
  output logic         instr_valid,
  output logic [N-1:0] instr_data,
  output logic [N-1:0] instr_pc,
  input  logic         instr_ready,
  input  logic         redirect_valid,
  input  logic [N-1:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {RUN, FULL, FLUSH} state_t;

  state_t         state, state_n;
  logic [N-1:0]   fetch_pc, cap_pc;
  logic [N-1:0]   head_data, head_pc;
  logic [N-1:0]   head_data_n, head_pc_n;
  logic [AW-1:0]  rd_ptr, wr_ptr, rd_nxt;
  logic [CW-1:0]  count, count_pop, used_n;
  logic           inflight;
  logic           issue, push, pop, head_load;

  logic [N-1:0]   q_data [DEPTH];
  logic [N-1:0]   q_pc   [DEPTH];

  // RUN is entered only when count+inflight<DEPTH, so the state alone gates
  // issue; a same-cycle pop is deliberately not credited (no look-ahead).
  always_comb begin
    issue       = reset && (state == RUN) && !redirect_valid;
    push        = inflight && !redirect_valid;
    pop         = (count != '0) && instr_ready && !redirect_valid;
    count_pop   = count - CW'(pop);
    rd_nxt      = rd_ptr + AW'(pop);
    used_n      = count_pop + CW'(push) + CW'(issue);
    // Head registers track the entry that will be at the head after this
    // edge; when the queue drains they keep the last head value.
    head_load   = (count_pop != '0) || push;
    head_data_n = (count_pop != '0) ? q_data[rd_nxt] : imem_rdata;
    head_pc_n   = (count_pop != '0) ? q_pc[rd_nxt]   : cap_pc;
    state_n     = RUN;
    if (redirect_valid)        state_n = FLUSH;
    else if (state == FLUSH)   state_n = RUN;
    else if (used_n == CW'(DEPTH)) state_n = FULL;
  end

  assign imem_req    = issue;
  assign imem_addr   = fetch_pc;
  assign instr_valid = (count != '0);
  assign instr_data  = head_data;
  assign instr_pc    = head_pc;

  // Control state: FSM, fetch PC, in-flight tracking, pointers, head regs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      cap_pc    <= '0;
      inflight  <= 1'b0;
      count     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      head_data <= '0;
      head_pc   <= '0;
    end else begin
      state <= state_n;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~N'(3);
        inflight <= 1'b0;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (issue) begin
          fetch_pc <= fetch_pc + N'(4);
          cap_pc   <= fetch_pc;
        end
        inflight <= issue;
        count    <= count_pop + CW'(push);
        if (pop)  rd_ptr <= rd_nxt;
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (head_load) begin
          head_data <= head_data_n;
          head_pc   <= head_pc_n;
        end
      end
    end
  end

  // Queue storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]   <= cap_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: memory model returning addr^key, a
// queue-based reference model checked every negedge, plus directed
// literal expectations for reset, start-up, back-pressure, redirect and wrap.
module tb_instr_fetch_queue;
  localparam int DEPTH = 4;
  localparam int N     = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         imem_req;
  logic [N-1:0] imem_addr;
  logic [N-1:0] imem_rdata = '0;
  logic         instr_valid;
  logic [N-1:0] instr_data, instr_pc;
  logic         instr_ready = 1'b1;
  logic         redirect_valid = 1'b0;
  logic [N-1:0] redirect_pc = '0;
  logic [N-1:0] key = '0;

  int checks = 0;
  int failures = 0;

  instr_fetch_queue #(.DEPTH(DEPTH), .N(N), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory: word at address a is a^key.
  always @(posedge clk) if (imem_req) imem_rdata <= imem_addr ^ key;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of (pc,data), fetch PC, one in-flight slot, flush flag.
  typedef struct { logic [N-1:0] pc; logic [N-1:0] data; } ent_t;
  ent_t         mq[$];
  logic [N-1:0] m_pc = '0, m_inf_pc = '0, m_last_pc = '0, m_last_data = '0;
  bit           m_inf = 0, m_flush = 0;

  function automatic bit m_req();
    return reset && !m_flush && !redirect_valid && ((mq.size() + int'(m_inf)) < DEPTH);
  endfunction

  always @(posedge clk or negedge reset) begin
    bit req;
    if (!reset) begin
      mq.delete(); m_pc = '0; m_inf = 0; m_inf_pc = '0; m_flush = 0;
      m_last_pc = '0; m_last_data = '0;
    end else begin
      req = m_req();
      if (redirect_valid) begin
        mq.delete();
        m_pc = redirect_pc & ~32'd3;
        m_inf = 0;
        m_flush = 1;
      end else begin
        if (mq.size() > 0 && instr_ready) void'(mq.pop_front());
        if (m_inf) mq.push_back('{m_inf_pc, m_inf_pc ^ key});
        m_flush = 0;
        m_inf = req;
        if (req) begin m_inf_pc = m_pc; m_pc = m_pc + 32'd4; end
      end
      if (mq.size() > 0) begin m_last_pc = mq[0].pc; m_last_data = mq[0].data; end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m_imem_req",   imem_req,    m_req());
    chk("m_imem_addr",  imem_addr,   m_pc);
    chk("m_instr_valid", instr_valid, mq.size() > 0);
    chk("m_instr_pc",   instr_pc,    (mq.size() > 0) ? mq[0].pc   : m_last_pc);
    chk("m_instr_data", instr_data,  (mq.size() > 0) ? mq[0].data : m_last_data);
  end

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic do_reset(input logic rdy, input logic [N-1:0] k);
    mid();
    reset = 1'b0; instr_ready = rdy; key = k; redirect_valid = 1'b0;
    repeat (3) mid();
    reset = 1'b1;
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int nreq, pops, cyc;
    logic [N-1:0] addrs [8];

    // Reset held 3 cycles, then release with ready high, identity memory.
    repeat (3) mid();
    #1;
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_data", instr_data, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    reset = 1'b1; #1;
    chk("start_req", imem_req, 1'b1);
    chk("start_addr", imem_addr, 32'h0);
    chk("start_valid", instr_valid, 1'b0);
    mid(); #1;
    chk("start_addr1", imem_addr, 32'h4);
    chk("start_valid1", instr_valid, 1'b0);
    // Stream: one instruction per cycle, data == pc.
    for (int k = 0; k < 10; k++) begin
      mid(); #1;
      chk("stream_valid", instr_valid, 1'b1);
      chk("stream_pc", instr_pc, 32'(4 * k));
      chk("stream_data", instr_data, 32'(4 * k));
    end

    // Back-pressure: exactly DEPTH requests while ready is low.
    do_reset(1'b0, 32'hA5A5_0000);
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) begin mid(); #1; end
      if (imem_req) begin
        if (nreq < 8) addrs[nreq] = imem_addr;
        nreq++;
      end
    end
    chk("bp_nreq", nreq, 4);
    for (int i = 0; i < 4; i++) chk("bp_addr", addrs[i], 32'(4 * i));
    instr_ready = 1'b1;
    pops = 0; cyc = 0;
    while (cyc < 20 && pops < 5) begin
      if (cyc > 0) begin mid(); #1; end
      if (instr_valid) begin
        chk("bp_pop_pc", instr_pc, 32'(4 * pops));
        chk("bp_pop_data", instr_data, 32'(4 * pops) ^ 32'hA5A5_0000);
        pops++;
      end
      cyc++;
    end
    chk("bp_pops", pops, 5);
    chk("bp_nogap", cyc, 5);

    // Redirect with two queued entries and a fetch in flight.
    do_reset(1'b0, 32'h0F0F_0000);
    mid(); mid(); mid();
    chk("rd_pre_valid", instr_valid, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 32'h103; #1;
    chk("rd_t_req", imem_req, 1'b0);
    mid(); redirect_valid = 1'b0; #1;
    chk("rd_flush_valid", instr_valid, 1'b0);
    chk("rd_flush_req", imem_req, 1'b0);
    mid(); #1;
    chk("rd_req", imem_req, 1'b1);
    chk("rd_addr", imem_addr, 32'h100);
    mid(); mid(); #1;
    chk("rd_valid", instr_valid, 1'b1);
    chk("rd_pc", instr_pc, 32'h100);
    chk("rd_data", instr_data, 32'h100 ^ 32'h0F0F_0000);

    // Redirect coinciding with a pop, then re-redirect during FLUSH.
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300; #1;
    mid(); redirect_pc = 32'h200; #1;
    chk("rr_valid", instr_valid, 1'b0);
    chk("rr_req", imem_req, 1'b0);
    mid(); redirect_valid = 1'b0; #1;
    chk("rr_flush_req", imem_req, 1'b0);
    chk("rr_flush_valid", instr_valid, 1'b0);
    mid(); #1;
    chk("rr_req2", imem_req, 1'b1);
    chk("rr_addr", imem_addr, 32'h200);
    mid(); mid(); #1;
    chk("rr_pc", instr_pc, 32'h200);
    repeat (4) mid();

    // Asynchronous reset between edges.
    reset = 1'b0; #1;
    chk("ar_req", imem_req, 1'b0);
    chk("ar_addr", imem_addr, 32'h0);
    chk("ar_valid", instr_valid, 1'b0);
    chk("ar_data", instr_data, 32'h0);
    chk("ar_pc", instr_pc, 32'h0);
    mid(); mid(); reset = 1'b1; #1;
    chk("ar_rel_req", imem_req, 1'b1);
    chk("ar_rel_addr", imem_addr, 32'h0);

    // Fetch PC wrap at the top of the address space.
    mid(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE; #1;
    mid(); redirect_valid = 1'b0; #1;
    mid(); #1;
    chk("wr_addr0", imem_addr, 32'hFFFF_FFFC);
    mid(); #1;
    chk("wr_addr1", imem_addr, 32'h0);
    mid(); #1;
    chk("wr_pc0", instr_pc, 32'hFFFF_FFFC);
    mid(); #1;
    chk("wr_pc1", instr_pc, 32'h0);
    repeat (3) mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
